// File: rtl/multiple_transfer_sequencer.sv
// Load/store-multiple sequencer: walks a 16-bit register list in ascending order, issues one
// word transfer per set bit over a req/ack memory port and produces the base writeback.
module multiple_transfer_sequencer #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [15:0]       reg_list,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [3:0]        base_reg,
    input  logic              load,
    input  logic              pre,
    input  logic              up,
    input  logic              writeback,
    output logic              busy,
    output logic              done,
    output logic [3:0]        rf_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              rf_wr_en,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              base_wb_en,
    output logic [ADDR_W-1:0] base_wb_value
);

    localparam int unsigned LIST_W = 16;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned CNT_W  = 5;
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ISSUE,
        S_XFER,
        S_LOADWR,
        S_WB,
        S_FIN
    } state_t;

    state_t state, next_state;

    logic [LIST_W-1:0] list_q, rem_q, rem_next;
    logic [ADDR_W-1:0] base_q, span, first_addr, final_addr;
    logic [IDX_W-1:0]  base_reg_q;
    logic              load_q, pre_q, up_q, wb_q;
    logic [CNT_W-1:0]  count;
    logic              has_more, advance, wb_allowed;
    logic              busy_nxt, done_nxt, mem_req_nxt, mem_we_nxt, rf_wr_en_nxt, base_wb_en_nxt;

    function automatic logic [CNT_W-1:0] count_ones(input logic [LIST_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < LIST_W; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    function automatic logic [IDX_W-1:0] lowest_set(input logic [LIST_W-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = LIST_W - 1; i >= 0; i--) if (v[i]) r = IDX_W'(i);
        return r;
    endfunction

    // Address block arithmetic: lowest register always sits at the lowest address.
    always_comb begin
        count      = count_ones(list_q);
        span       = ADDR_W'(count) << 2;
        final_addr = up_q ? base_q + span : base_q - span;
        case ({pre_q, up_q})
            2'b01:   first_addr = base_q;
            2'b11:   first_addr = base_q + ADDR_STEP;
            2'b00:   first_addr = base_q - span + ADDR_STEP;
            default: first_addr = base_q - span;
        endcase
        rem_next   = rem_q & ~(LIST_W'(1) << rf_addr);
        has_more   = |rem_next;
        advance    = ((state == S_XFER) && mem_ack && !load_q) || (state == S_LOADWR);
        wb_allowed = wb_q && !(load_q && list_q[base_reg_q]);
    end

    // State register together with the registered control outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            rf_wr_en   <= 1'b0;
            base_wb_en <= 1'b0;
        end else begin
            state      <= next_state;
            busy       <= busy_nxt;
            done       <= done_nxt;
            mem_req    <= mem_req_nxt;
            mem_we     <= mem_we_nxt;
            rf_wr_en   <= rf_wr_en_nxt;
            base_wb_en <= base_wb_en_nxt;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start) next_state = S_SETUP;
            S_SETUP:  next_state = (list_q == '0) ? S_FIN : S_ISSUE;
            S_ISSUE:  next_state = S_XFER;
            S_XFER: begin
                if (mem_ack) begin
                    if (load_q)        next_state = S_LOADWR;
                    else if (has_more) next_state = S_ISSUE;
                    else               next_state = S_WB;
                end
            end
            S_LOADWR: next_state = has_more ? S_ISSUE : S_WB;
            S_WB:     next_state = S_FIN;
            S_FIN:    next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Control outputs are decoded from the upcoming state so they line up with it once registered.
    always_comb begin
        busy_nxt       = 1'b0;
        done_nxt       = 1'b0;
        mem_req_nxt    = 1'b0;
        mem_we_nxt     = 1'b0;
        rf_wr_en_nxt   = 1'b0;
        base_wb_en_nxt = 1'b0;
        busy_nxt       = (next_state != S_IDLE);
        done_nxt       = (next_state == S_FIN);
        mem_req_nxt    = (next_state == S_XFER);
        mem_we_nxt     = (next_state == S_XFER) && !load_q;
        rf_wr_en_nxt   = (next_state == S_LOADWR);
        base_wb_en_nxt = (next_state == S_WB) && wb_allowed;
    end

    // Operand latch and transfer datapath.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            list_q        <= '0;
            rem_q         <= '0;
            base_q        <= '0;
            base_reg_q    <= '0;
            load_q        <= 1'b0;
            pre_q         <= 1'b0;
            up_q          <= 1'b0;
            wb_q          <= 1'b0;
            rf_addr       <= '0;
            rf_wr_data    <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            base_wb_value <= '0;
        end else begin
            if ((state == S_IDLE) && start) begin
                list_q     <= reg_list;
                base_q     <= base_addr;
                base_reg_q <= base_reg;
                load_q     <= load;
                pre_q      <= pre;
                up_q       <= up;
                wb_q       <= writeback;
            end
            if (state == S_SETUP) begin
                rem_q         <= list_q;
                rf_addr       <= lowest_set(list_q);
                mem_addr      <= first_addr;
                base_wb_value <= final_addr;
            end
            if ((state == S_ISSUE) && !load_q) mem_wdata <= rf_rd_data;
            if ((state == S_XFER) && mem_ack && load_q) rf_wr_data <= mem_rdata;
            if (advance) begin
                rem_q <= rem_next;
                if (has_more) begin
                    rf_addr  <= lowest_set(rem_next);
                    mem_addr <= mem_addr + ADDR_STEP;
                end
            end
        end
    end

endmodule
